// File: rtl/vga_tile_pkg.sv
// Shared timing defaults, raster helper functions and the stage-0 signal
// bundle used by the VGA tile scanner and its timing generator.
package vga_tile_pkg;

  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_H_FP       = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BP       = 48;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int DEF_V_FP       = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BP       = 33;
  localparam int DEF_SYNC_POL   = 0;
  localparam int DEF_IMG_W_LOG2 = 7;
  localparam int DEF_IMG_H_LOG2 = 6;
  localparam int DEF_ADDRESS    = 13;
  localparam int DEF_COLOR_BITS = 24;

  function automatic int h_total(input int active, input int fp,
                                 input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp,
                                 input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Counter width for a 0..total-1 range; never narrower than one bit.
  function automatic int cnt_width(input int total);
    return (total <= 2) ? 1 : $clog2(total);
  endfunction

  // Stage-0 decode of the current raster position.
  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic first;
  } raw_t;

endpackage

// File: rtl/vga_tile_scan_if.sv
// ROM address/data port plus registered video outputs of the tile scanner.
// addr is combinational from the raster counters; dout must return the word
// for addr in the same cycle. rgb/hsync/vsync/de/frame_start are registered
// and mutually aligned; there is no valid/ready flow control, pixels advance
// on the pixel clock enable.
interface vga_tile_scan_if #(
  parameter int ADDRESS    = 13,
  parameter int COLOR_BITS = 24
);
  logic [ADDRESS-1:0]    addr;
  logic [COLOR_BITS-1:0] dout;
  logic [COLOR_BITS-1:0] rgb;
  logic                  hsync;
  logic                  vsync;
  logic                  de;
  logic                  frame_start;

  modport master (
    output addr,
    input  dout,
    output rgb,
    output hsync,
    output vsync,
    output de,
    output frame_start
  );

  modport slave (
    input  addr,
    output dout,
    input  rgb,
    input  hsync,
    input  vsync,
    input  de,
    input  frame_start
  );
endinterface

// File: rtl/vga_timing.sv
// Raster counters with combinational active/sync/first-pixel decode.
// Reusable by any raster source that registers its pixels one enable later.
module vga_timing
  import vga_tile_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int SYNC_POL = DEF_SYNC_POL,
  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int HW      = cnt_width(H_TOTAL),
  localparam int VW      = cnt_width(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_ce_i,
  output logic [HW-1:0] hcnt_o,
  output logic [VW-1:0] vcnt_o,
  output raw_t          raw_o
);

  localparam logic          SYNC_ON  = (SYNC_POL != 0);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_S = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_E = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_SYNC_S = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_E = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          h_in_sync;
  logic          v_in_sync;

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (pix_ce_i) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  // Sync windows are half-open: [start, start+width).
  assign h_in_sync = (hcnt_q >= H_SYNC_S) && (hcnt_q < H_SYNC_E);
  assign v_in_sync = (vcnt_q >= V_SYNC_S) && (vcnt_q < V_SYNC_E);

  always_comb begin
    raw_o       = '0;
    raw_o.act   = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
    raw_o.hs    = h_in_sync ? SYNC_ON : ~SYNC_ON;
    raw_o.vs    = v_in_sync ? SYNC_ON : ~SYNC_ON;
    raw_o.first = (hcnt_q == '0) && (vcnt_q == '0);
  end

  assign hcnt_o = hcnt_q;
  assign vcnt_o = vcnt_q;

endmodule

// File: rtl/vga_tile_scan.sv
// VGA raster scanner that tiles a 2^IMG_W_LOG2 x 2^IMG_H_LOG2 ROM image over
// the visible area and emits colour, syncs and enable aligned on one register.
module vga_tile_scan
  import vga_tile_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int SYNC_POL   = DEF_SYNC_POL,
  parameter int IMG_W_LOG2 = DEF_IMG_W_LOG2,
  parameter int IMG_H_LOG2 = DEF_IMG_H_LOG2,
  parameter int ADDRESS    = DEF_ADDRESS,
  parameter int COLOR_BITS = DEF_COLOR_BITS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pix_ce,
  vga_tile_scan_if.master vid
);

  localparam int   H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int   V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int   HW      = cnt_width(H_TOTAL);
  localparam int   VW      = cnt_width(V_TOTAL);
  localparam logic SYNC_ON = (SYNC_POL != 0);

  if (ADDRESS != IMG_W_LOG2 + IMG_H_LOG2) begin : g_bad_address
    $error("vga_tile_scan: ADDRESS must equal IMG_W_LOG2 + IMG_H_LOG2");
  end

  typedef logic [COLOR_BITS-1:0] color_t;

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  raw_t          raw;
  logic          unused_cnt_hi;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_timing (
    .clk      (clk),
    .rst_n    (rst_n),
    .pix_ce_i (pix_ce),
    .hcnt_o   (hcnt),
    .vcnt_o   (vcnt),
    .raw_o    (raw)
  );

  // Dropping the high counter bits repeats the image across the screen.
  assign vid.addr      = {vcnt[IMG_H_LOG2-1:0], hcnt[IMG_W_LOG2-1:0]};
  assign unused_cnt_hi = ^{hcnt[HW-1:IMG_W_LOG2], vcnt[VW-1:IMG_H_LOG2]};

  color_t rgb_q, rgb_d;
  logic   de_q, de_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;
  logic   frame_start_q, frame_start_d;

  always_comb begin
    rgb_d         = rgb_q;
    de_d          = de_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    // Cleared on idle cycles so the pulse is one clk wide at any enable rate.
    frame_start_d = 1'b0;
    if (pix_ce) begin
      rgb_d         = raw.act ? vid.dout : '0;
      de_d          = raw.act;
      hsync_d       = raw.hs;
      vsync_d       = raw.vs;
      frame_start_d = raw.first;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q         <= '0;
      de_q          <= 1'b0;
      hsync_q       <= ~SYNC_ON;
      vsync_q       <= ~SYNC_ON;
      frame_start_q <= 1'b0;
    end else begin
      rgb_q         <= rgb_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vid.rgb         = rgb_q;
  assign vid.de          = de_q;
  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_tile_scan.sv
// Directed bench: a full-size 640x480 scanner for pixel/line behaviour and a
// shrunken, active-high-sync scanner for frame-level timing and slow enables.
module tb_vga_tile_scan;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic ce_a     = 1'b0;
  logic ce_s     = 1'b0;
  logic force_ff = 1'b0;

  always #5 clk = ~clk;

  vga_tile_scan_if #(.ADDRESS(13), .COLOR_BITS(24)) vid_a ();
  vga_tile_scan_if #(.ADDRESS(5),  .COLOR_BITS(24)) vid_s ();

  // ROM model: colour equals zero-extended address, or all-ones when forced.
  assign vid_a.dout = force_ff ? 24'hFFFFFF : 24'(vid_a.addr);
  assign vid_s.dout = 24'(vid_s.addr);

  vga_tile_scan u_dut_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_ce (ce_a),
    .vid    (vid_a)
  );

  // Small raster: 32 x 20 total, 16 x 10 visible, syncs active-high.
  vga_tile_scan #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(10), .V_FP(3), .V_SYNC(2), .V_BP(5),
    .SYNC_POL(1), .IMG_W_LOG2(3), .IMG_H_LOG2(2), .ADDRESS(5), .COLOR_BITS(24)
  ) u_dut_s (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_ce (ce_s),
    .vid    (vid_s)
  );

  int checks = 0;
  int fails  = 0;
  int n_a    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (ce_a) n_a++;
  endtask

  task automatic run_to(input int target);
    int guard = 0;
    while (n_a < target && guard < 20000) begin
      step();
      guard++;
    end
  endtask

  initial begin
    int bad, hs_first, hs_cnt;
    int nce_s, idx, fs_hi, fs1, fs2, vs_first, vs_cnt, chg;
    logic [26:0] prev;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rgb",   vid_a.rgb,         0);
    check("rst_de",    vid_a.de,          0);
    check("rst_fs",    vid_a.frame_start, 0);
    check("rst_hs",    vid_a.hsync,       1);
    check("rst_vs",    vid_a.vsync,       1);
    check("rst_s_hs",  vid_s.hsync,       0);
    check("rst_s_vs",  vid_s.vsync,       0);

    // Continuous enable, first pixels of line 0
    rst_n = 1'b1;
    ce_a  = 1'b1;
    step();
    check("p0_rgb", vid_a.rgb,         0);
    check("p0_de",  vid_a.de,          1);
    check("p0_fs",  vid_a.frame_start, 1);
    check("p0_hs",  vid_a.hsync,       1);
    step();
    check("p1_rgb", vid_a.rgb,         1);
    check("p1_fs",  vid_a.frame_start, 0);
    run_to(8);
    check("p7_rgb", vid_a.rgb, 24'h000007);

    // Line wrap: line 1 pixel 130 -> addr {1, 2} = 0x082
    run_to(931);
    check("l1p130_rgb", vid_a.rgb, 24'h000082);
    check("l1p130_de",  vid_a.de,  1);

    // Blanking with an all-ones ROM
    force_ff = 1'b1;
    run_to(1440);
    check("l1p639_rgb", vid_a.rgb, 24'hFFFFFF);
    check("l1p639_de",  vid_a.de,  1);
    run_to(1441);
    check("l1p640_rgb", vid_a.rgb, 0);
    check("l1p640_de",  vid_a.de,  0);
    bad = 0;
    while (n_a < 1600) begin
      step();
      if (vid_a.rgb !== 24'h0 || vid_a.de !== 1'b0) bad++;
    end
    check("blank_bad", bad, 0);
    run_to(1601);
    check("l2p0_rgb", vid_a.rgb,   24'hFFFFFF);
    check("l2p0_de",  vid_a.de,    1);
    check("l2p0_hs",  vid_a.hsync, 1);
    force_ff = 1'b0;

    // Horizontal sync window on line 2
    hs_first = -1;
    hs_cnt   = 0;
    for (int i = 1; i < 800; i++) begin
      step();
      if (vid_a.hsync === 1'b0) begin
        if (hs_first < 0) hs_first = n_a - 1 - 1600;
        hs_cnt++;
      end
    end
    check("hs_start", hs_first, 656);
    check("hs_width", hs_cnt,   96);

    // Line 3 pixel 299 -> addr {3, 43} = 0x1AB
    run_to(2700);
    check("l3p299_rgb", vid_a.rgb, 24'h0001AB);

    // Small raster at 1-of-4 enable; full-size raster frozen
    ce_a     = 1'b0;
    nce_s    = 0;
    fs_hi    = 0;
    fs1      = -1;
    fs2      = -1;
    vs_first = -1;
    vs_cnt   = 0;
    chg      = 0;
    prev = {vid_s.rgb, vid_s.de, vid_s.hsync, vid_s.vsync};
    for (int c = 0; c < 4 * 1282; c++) begin
      ce_s = (c % 4 == 0);
      @(posedge clk);
      @(negedge clk);
      if (ce_s) begin
        nce_s++;
        idx = nce_s - 1;
        if (vid_s.vsync === 1'b1 && idx < 640) begin
          if (vs_first < 0) vs_first = idx;
          vs_cnt++;
        end
      end else if ({vid_s.rgb, vid_s.de, vid_s.hsync, vid_s.vsync} !== prev) begin
        chg++;
      end
      if (vid_s.frame_start === 1'b1) begin
        fs_hi++;
        if (fs1 < 0) fs1 = nce_s;
        else if (fs2 < 0) fs2 = nce_s;
      end
      prev = {vid_s.rgb, vid_s.de, vid_s.hsync, vid_s.vsync};
    end
    ce_s = 1'b0;
    check("s_idle_changes", chg,       0);
    check("s_fs_clks",      fs_hi,     3);
    check("s_frame_period", fs2 - fs1, 640);
    check("s_vs_start",     vs_first,  416);
    check("s_vs_width",     vs_cnt,    64);
    check("s_f2p1_de",      vid_s.de,  1);
    check("s_f2p1_rgb",     vid_s.rgb, 1);
    check("hold_rgb", vid_a.rgb, 24'h0001AB);
    check("hold_de",  vid_a.de,  1);

    // Asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    ce_a  = 1'b1;
    ce_s  = 1'b1;
    #1;
    check("arst_rgb",  vid_a.rgb,   0);
    check("arst_de",   vid_a.de,    0);
    check("arst_hs",   vid_a.hsync, 1);
    check("arst_vs",   vid_a.vsync, 1);
    check("arst_s_de", vid_s.de,    0);
    check("arst_s_hs", vid_s.hsync, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("arst_hold_de", vid_a.de, 0);
    rst_n = 1'b1;
    n_a   = 0;
    step();
    check("rel_rgb",  vid_a.rgb,         0);
    check("rel_de",   vid_a.de,          1);
    check("rel_fs",   vid_a.frame_start, 1);
    check("rel_s_fs", vid_s.frame_start, 1);
    step();
    check("rel_p1_rgb", vid_a.rgb,         1);
    check("rel_p1_fs",  vid_a.frame_start, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
